dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the data word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 9, meaning the word address width (512 words).
REQ-003 The module SHALL have parameter INIT_WORDS, default 16, legal range 1..2^ADDR_WIDTH, meaning the number of words written during post-reset initialisation.
REQ-004 The module SHALL have a single clock and an asynchronous, active-high reset; all other ports below are synchronous to clk.
REQ-005 The module SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- cpu_req, dbg_req  in  1  request from the CPU and debug requesters.
- cpu_we, dbg_we  in  1  request is a write (1) or a read (0).
- cpu_addr, dbg_addr  in  ADDR_WIDTH  word address.
- cpu_wd, dbg_wd  in  DATA_WIDTH  write data.
- cpu_gnt, dbg_gnt  out  1  request accepted this cycle.
- cpu_rvalid, dbg_rvalid  out  1  read data valid.
- cpu_rdata, dbg_rdata  out  DATA_WIDTH  read data.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_we  out  1  memory write enable.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_rd  in  DATA_WIDTH  memory read data, registered with 1-cycle latency.
- init_done  out  1  initialisation complete.

Function
REQ-006 The FSM SHALL have two states, INIT and SERVE; reset SHALL force INIT with init counter cnt=0.
REQ-007 In INIT, each cycle the module SHALL drive mem_we=1, mem_addr=cnt and mem_wd=cnt (zero-extended), then increment cnt.
REQ-008 When the INIT cycle with cnt=INIT_WORDS-1 completes, the FSM SHALL enter SERVE and set init_done=1; init_done SHALL remain 1 until reset.
REQ-009 In INIT, cpu_gnt and dbg_gnt SHALL be 0 regardless of the requests; requesters SHALL hold req, we, addr and wd stable until they are granted.
REQ-010 In SERVE, the grant SHALL be combinational and issued in the same cycle as the request; at most one gnt SHALL be high per cycle.
REQ-011 If only one requester asserts req, it SHALL be granted.
REQ-012 If both requesters assert req, the requester not granted most recently SHALL be granted (round-robin); after reset, priority SHALL go to cpu.
REQ-013 The round-robin pointer SHALL update only on cycles in which a grant is issued.
REQ-014 In a granted cycle, mem_addr, mem_we and mem_wd SHALL equal the granted requester's addr, we and wd, combinationally.
REQ-015 With no grant in SERVE, the module SHALL drive mem_we=0, mem_addr=0 and mem_wd=0.
REQ-016 A granted read in cycle N SHALL produce an rvalid pulse for that requester in cycle N+1, with rdata=mem_rd in that cycle.
REQ-017 rdata SHALL be 0 whenever the corresponding rvalid is 0.
REQ-018 A granted write SHALL produce no rvalid.
REQ-019 Back-to-back grants SHALL be supported: one transaction per cycle, with reads and writes fully pipelined.
REQ-020 The arbiter SHALL NOT forward write data internally: a read granted in the cycle after a write to the same address returns the memory's contents, which already hold the new value.
REQ-021 A req asserted without a grant SHALL have no side effects.

Reset
REQ-022 While reset=1, all outputs SHALL be 0: gnt, rvalid, rdata, mem_we, mem_addr, mem_wd and init_done.
REQ-023 Reset asserted mid-INIT or mid-SERVE SHALL immediately return the FSM to INIT with cnt=0 and the round-robin pointer set to cpu.
REQ-024 Reset SHALL discard any pending rvalid, so no rvalid is issued for a read granted in the cycle reset asserts.
REQ-025 After reset deasserts, initialisation SHALL restart from address 0.

Verification
REQ-026 Deassert reset and hold cpu_req=1 throughout -> for 16 cycles mem_we=1, mem_addr=mem_wd=0..15, cpu_gnt=0; in cycle 17 init_done=1 and cpu_gnt=1.
REQ-027 After init, issue cpu read of address 5 -> cpu_rvalid=1 one cycle after the grant, with cpu_rdata=5.
REQ-028 Hold cpu_req=dbg_req=1 for 4 cycles after init -> grants go cpu, dbg, cpu, dbg.
REQ-029 dbg write addr 20 with data 0xDEADBEEF, followed next cycle by a dbg read of addr 20 -> dbg_rdata=0xDEADBEEF; cpu_rvalid stays 0 throughout.
REQ-030 Assert reset at the 8th INIT cycle, then release -> all outputs 0 during reset, and INIT restarts with mem_addr=0.
REQ-031 Assert reset in the cycle after a cpu read is granted -> no cpu_rvalid pulse; init_done=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/debug arbiter for a single-port data memory,
// preceded by a post-reset sweep that writes each init word with its own address.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int INIT_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wd,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wd,
  output logic                  cpu_gnt,
  output logic                  dbg_gnt,
  output logic                  cpu_rvalid,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  init_done
);
  typedef enum logic {INIT, SERVE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(INIT_WORDS - 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  dbg_pri_q, dbg_pri_d;
  logic                  cpu_rv_q, dbg_rv_q;
  logic                  serve;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  always_comb state_d = (state_q == INIT && cnt_q == LAST) ? SERVE : state_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q     <= '0;
      dbg_pri_q <= 1'b0;
      cpu_rv_q  <= 1'b0;
      dbg_rv_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dbg_pri_q <= dbg_pri_d;
      cpu_rv_q  <= cpu_gnt && !cpu_we;
      dbg_rv_q  <= dbg_gnt && !dbg_we;
    end
  // Outputs are gated by reset directly so they read 0 for the whole reset window.
  always_comb begin
    serve      = state_q == SERVE && !reset;
    cpu_gnt    = serve && cpu_req && (!dbg_req || !dbg_pri_q);
    dbg_gnt    = serve && dbg_req && (!cpu_req || dbg_pri_q);
    cnt_d      = state_q == INIT ? cnt_q + 1'b1 : cnt_q;
    dbg_pri_d  = cpu_gnt ? 1'b1 : dbg_gnt ? 1'b0 : dbg_pri_q;
    mem_we     = reset ? 1'b0 : state_q == INIT ? 1'b1 :
                 cpu_gnt ? cpu_we : dbg_gnt ? dbg_we : 1'b0;
    mem_addr   = reset ? '0 : state_q == INIT ? cnt_q :
                 cpu_gnt ? cpu_addr : dbg_gnt ? dbg_addr : '0;
    mem_wd     = reset ? '0 : state_q == INIT ? DATA_WIDTH'(cnt_q) :
                 cpu_gnt ? cpu_wd : dbg_gnt ? dbg_wd : '0;
    init_done  = serve;
    cpu_rvalid = cpu_rv_q;
    dbg_rvalid = dbg_rv_q;
    cpu_rdata  = cpu_rv_q ? mem_rd : '0;
    dbg_rdata  = dbg_rv_q ? mem_rd : '0;
  end
endmodule
